button_event_decoder_mc: RTL

//  Multi-channel successor to the single-button decoder. It synchronises and debounces
//  NUM_BTN raw button inputs, then classifies each press as short, long or auto-repeat.
//  Per-channel press/release/short/long/repeat events are emitted as 1-cycle strobes for the

---
 rtl/button_event_decoder_mc.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/button_event_decoder_mc.sv
// Multi-channel button decoder: synchronise, debounce and classify each press as
// press/release/short/long/auto-repeat strobes on a shared millisecond time base.
module button_event_decoder_mc #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SHORT_MS    = 50,
  parameter int unsigned LONG_MS     = 300,
  parameter int unsigned REPEAT_MS   = 100
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] evt_press,
  output logic [NUM_BTN-1:0] evt_release,
  output logic [NUM_BTN-1:0] evt_short,
  output logic [NUM_BTN-1:0] evt_long,
  output logic [NUM_BTN-1:0] evt_repeat
);

  localparam int unsigned MS_DIV = CLK_HZ / 1000;
  localparam int unsigned PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int unsigned DBW    = 8;
  localparam int unsigned HW     = 16;
  localparam logic [NUM_BTN-1:0] REL_LVL = (ACTIVE_LOW != 0) ? '1 : '0;

  if (CLK_HZ < 1000) begin : g_bad_clk
    $error("button_event_decoder_mc: CLK_HZ must be >= 1000");
  end
  if (SHORT_MS >= LONG_MS) begin : g_bad_short
    $error("button_event_decoder_mc: SHORT_MS must be < LONG_MS");
  end
  if (NUM_BTN < 1 || NUM_BTN > 16) begin : g_bad_num
    $error("button_event_decoder_mc: NUM_BTN must be in 1..16");
  end

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_e;

  logic [PW-1:0]      div_q, div_d;
  logic               tick_q, tick_d;
  logic               fsm_tick_q, fsm_tick_d;
  logic [NUM_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_BTN-1:0] s;

  // Shared ms prescaler and 2-FF synchroniser; the FSMs run one cycle behind the
  // debouncer, so they see a one-cycle-delayed tick that lines up with db edges.
  always_comb begin
    div_d      = div_q + PW'(1);
    tick_d     = 1'b0;
    fsm_tick_d = tick_q;
    if (div_q == PW'(MS_DIV - 1)) begin
      div_d  = '0;
      tick_d = 1'b1;
    end
    sync1_d = btn_in;
    sync2_d = sync1_q;
    s       = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q      <= '0;
      tick_q     <= 1'b0;
      fsm_tick_q <= 1'b0;
      sync1_q    <= REL_LVL;
      sync2_q    <= REL_LVL;
    end else begin
      div_q      <= div_d;
      tick_q     <= tick_d;
      fsm_tick_q <= fsm_tick_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           db_q, db_d;
    logic           lvl_q, lvl_d;
    state_e         state_q, state_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [HW-1:0]  rep_q, rep_d;
    logic           press_q, press_d, rel_q, rel_d, short_q, short_d;
    logic           long_q, long_d, rpt_q, rpt_d;
    logic           rise, fall;

    // Debounce: accept a new level once it has survived DEBOUNCE_MS full ticks.
    always_comb begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      if (s[i] == db_q) begin
        db_cnt_d = '0;
      end else if (tick_q) begin
        if (db_cnt_q == DBW'(DEBOUNCE_MS)) begin
          db_d     = s[i];
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end
    end

    // Press classifier; a release always takes priority over long/repeat.
    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      lvl_d   = db_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      rise    = db_q & ~lvl_q;
      fall    = ~db_q & lvl_q;
      case (state_q)
        IDLE: begin
          if (rise) begin
            press_d = 1'b1;
            hold_d  = '0;
            state_d = HELD;
          end
        end
        HELD: begin
          if (fall) begin
            rel_d   = 1'b1;
            short_d = (hold_q >= HW'(SHORT_MS));
            state_d = IDLE;
          end else if (fsm_tick_q) begin
            hold_d = hold_q + HW'(1);
            if (hold_q + HW'(1) == HW'(LONG_MS)) begin
              long_d  = 1'b1;
              rep_d   = '0;
              state_d = LONG;
            end
          end
        end
        LONG: begin
          if (fall) begin
            rel_d   = 1'b1;
            state_d = IDLE;
          end else if (fsm_tick_q && (REPEAT_MS != 0)) begin
            if (rep_q + HW'(1) == HW'(REPEAT_MS)) begin
              rpt_d = 1'b1;
              rep_d = '0;
            end else begin
              rep_d = rep_q + HW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        db_cnt_q <= '0;
        db_q     <= 1'b0;
        lvl_q    <= 1'b0;
        state_q  <= IDLE;
        hold_q   <= '0;
        rep_q    <= '0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        short_q  <= 1'b0;
        long_q   <= 1'b0;
        rpt_q    <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        db_q     <= db_d;
        lvl_q    <= lvl_d;
        state_q  <= state_d;
        hold_q   <= hold_d;
        rep_q    <= rep_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        short_q  <= short_d;
        long_q   <= long_d;
        rpt_q    <= rpt_d;
      end
    end

    assign btn_level[i]   = lvl_q;
    assign evt_press[i]   = press_q;
    assign evt_release[i] = rel_q;
    assign evt_short[i]   = short_q;
    assign evt_long[i]    = long_q;
    assign evt_repeat[i]  = rpt_q;
  end

endmodule
